// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle between the requesters, the arbiter and
// the downstream FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int M = 4,
  parameter int R = 4
);
  logic [R-1:0]   req_valid;
  logic [R*M-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic [R-1:0]   grant;
  logic           busy;
  logic           full;
  logic           we;
  logic [M-1:0]   wd;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, grant, busy, we, wd
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, grant, busy, we, wd
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: R requesters share one FIFO write port,
// each grant carrying up to BURST words.
module fifo_wr_arbiter #(
  parameter int M     = 4,
  parameter int R     = 4,
  parameter int BURST = 4
) (
  input logic         clk,
  input logic         reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] sel, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [R-1:0]  grant, grant_n;
  logic          found;
  logic          ovalid;
  logic          xfer;
  logic          last;
  int            j;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < R; k++) begin
      j = (int'(ptr) + k) % R;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  assign ovalid = bus.req_valid[owner];
  assign xfer   = (state == BUSY) && ovalid && !bus.full;
  assign last   = (cnt == CW'(BURST - 1));
  assign nxt    = (owner == IW'(R - 1)) ? '0 : owner + IW'(1);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          owner_n = sel;
          grant_n = R'(1) << sel;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        // Dropped valid releases even under backpressure.
        if (!ovalid || (xfer && last)) begin
          state_n = IDLE;
          ptr_n   = nxt;
          grant_n = '0;
          cnt_n   = '0;
        end else if (xfer) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      grant <= grant_n;
    end
  end

  assign bus.grant     = grant;
  assign bus.busy      = (state == BUSY);
  assign bus.we        = xfer;
  assign bus.wd        = bus.req_data[int'(owner)*M +: M];
  assign bus.req_ready = ((state == BUSY) && !bus.full) ? grant : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, round-robin,
// backpressure, early drop and asynchronous reset.
module tb_fifo_wr_arbiter;

  localparam logic [15:0] DAT = 16'hDCBA;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  fifo_wr_arbiter_if #(.M(4), .R(4)) bus ();

  fifo_wr_arbiter #(
    .M(4),
    .R(4),
    .BURST(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] g,
                     input logic b,
                     input logic w,
                     input logic [3:0] d);
    logic [3:0] rdy;
    rdy = (b && !bus.full) ? g : 4'b0;
    cmp({tag, ".grant"}, 32'(bus.grant), 32'(g));
    cmp({tag, ".busy"}, 32'(bus.busy), 32'(b));
    cmp({tag, ".we"}, 32'(bus.we), 32'(w));
    cmp({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    if (w) cmp({tag, ".wd"}, 32'(bus.wd), 32'(d));
  endtask

  task automatic tick(input logic [3:0] v,
                      input logic [15:0] d,
                      input logic f);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.full      = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;
    #1;
    chk("rst", 4'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;

    // single requester, data 1..6
    do_reset();
    tick(4'b0001, 16'h1, 1'b0);
    chk("s_idle", 4'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 1; i <= 4; i++) begin
      tick(4'b0001, 16'(i), 1'b0);
      chk("s_wr", 4'b0001, 1'b1, 1'b1, 4'(i));
    end
    tick(4'b0001, 16'h5, 1'b0);
    chk("s_gap", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'b0001, 16'h5, 1'b0);
    chk("s_wr5", 4'b0001, 1'b1, 1'b1, 4'h5);
    tick(4'b0001, 16'h6, 1'b0);
    chk("s_wr6", 4'b0001, 1'b1, 1'b1, 4'h6);
    tick(4'b0000, 16'h0, 1'b0);
    chk("s_drop", 4'b0001, 1'b1, 1'b0, 4'h0);
    tick(4'b0000, 16'h0, 1'b0);
    chk("s_end", 4'b0, 1'b0, 1'b0, 4'h0);

    // round-robin with all requesters valid
    do_reset();
    for (int g = 0; g < 5; g++) begin
      tick(4'hF, DAT, 1'b0);
      chk("rr_idle", 4'b0, 1'b0, 1'b0, 4'h0);
      for (int n = 0; n < ((g < 4) ? 4 : 1); n++) begin
        tick(4'hF, DAT, 1'b0);
        chk("rr_wr", 4'(1 << (g % 4)), 1'b1, 1'b1,
            4'(10 + g % 4));
      end
    end

    // backpressure after 2 writes
    do_reset();
    tick(4'b0001, DAT, 1'b0);
    chk("bp_idle", 4'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick(4'b0001, DAT, 1'b0);
      chk("bp_wr", 4'b0001, 1'b1, 1'b1, 4'hA);
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'b0001, DAT, 1'b1);
      chk("bp_stall", 4'b0001, 1'b1, 1'b0, 4'h0);
    end
    for (int i = 0; i < 2; i++) begin
      tick(4'b0001, DAT, 1'b0);
      chk("bp_rest", 4'b0001, 1'b1, 1'b1, 4'hA);
    end
    tick(4'b0001, DAT, 1'b0);
    chk("bp_rel", 4'b0, 1'b0, 1'b0, 4'h0);

    // early drop by owner 2, then wrap from 3 to 1
    do_reset();
    tick(4'b0100, DAT, 1'b0);
    chk("ed_idle", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'b0100, DAT, 1'b0);
    chk("ed_wr2", 4'b0100, 1'b1, 1'b1, 4'hC);
    tick(4'b1010, DAT, 1'b0);
    chk("ed_drop", 4'b0100, 1'b1, 1'b0, 4'h0);
    tick(4'b1010, DAT, 1'b0);
    chk("ed_idle2", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'b1010, DAT, 1'b0);
    chk("ed_g3", 4'b1000, 1'b1, 1'b1, 4'hD);
    tick(4'b0010, DAT, 1'b0);
    chk("ed_drop3", 4'b1000, 1'b1, 1'b0, 4'h0);
    tick(4'b0010, DAT, 1'b0);
    chk("ed_idle3", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'b0010, DAT, 1'b0);
    chk("ed_wrap", 4'b0010, 1'b1, 1'b1, 4'hB);

    // owner drops valid while full
    do_reset();
    tick(4'b0001, DAT, 1'b0);
    chk("df_idle", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'b0001, DAT, 1'b0);
    chk("df_wr", 4'b0001, 1'b1, 1'b1, 4'hA);
    tick(4'b0000, DAT, 1'b1);
    chk("df_drop", 4'b0001, 1'b1, 1'b0, 4'h0);
    tick(4'b0011, DAT, 1'b0);
    chk("df_idle2", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'b0011, DAT, 1'b0);
    chk("df_ptr", 4'b0010, 1'b1, 1'b1, 4'hB);

    // asynchronous reset in the middle of owner 1's burst
    do_reset();
    tick(4'hF, DAT, 1'b0);
    chk("ar_idle", 4'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick(4'hF, DAT, 1'b0);
      chk("ar_g0", 4'b0001, 1'b1, 1'b1, 4'hA);
    end
    tick(4'hF, DAT, 1'b0);
    chk("ar_gap", 4'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick(4'hF, DAT, 1'b0);
      chk("ar_g1", 4'b0010, 1'b1, 1'b1, 4'hB);
    end
    #1 reset = 1'b1;
    #1;
    chk("ar_abort", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'hF, DAT, 1'b0);
    reset = 1'b0;
    chk("ar_rel", 4'b0, 1'b0, 1'b0, 4'h0);
    tick(4'hF, DAT, 1'b0);
    chk("ar_first", 4'b0001, 1'b1, 1'b1, 4'hA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter M, default 4: data word width in bits.
REQ-002 SHALL have parameter R, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have parameter BURST, default 4: maximum words per grant, legal range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, R bits: bit i high means requester i presents a word.
REQ-007 SHALL have port req_data, input, R*M bits: requester i word on bits [i*M +: M].
REQ-008 SHALL have port req_ready, output, R bits: bit i high means requester i's word is accepted this cycle if valid.
REQ-009 SHALL have port grant, output, R bits: one-hot current owner, registered; all zero when no owner.
REQ-010 SHALL have port busy, output, 1 bit: high in state BUSY.
REQ-011 SHALL have port full, input, 1 bit: full flag of the downstream FIFO.
REQ-012 SHALL have port we, output, 1 bit: FIFO write enable.
REQ-013 SHALL have port wd, output, M bits: FIFO write data.

Function
REQ-014 SHALL implement two states, IDLE and BUSY, plus an owner index register, a round-robin pointer ptr (0..R-1) and a burst counter cnt (0..BURST).
REQ-015 In IDLE with any req_valid set, SHALL select the first valid requester searching ptr, ptr+1, ... mod R, load owner and set grant one-hot, clear cnt, and enter BUSY on the next edge.
REQ-016 In IDLE with no req_valid set, SHALL remain in IDLE with grant=0.
REQ-017 In IDLE, req_ready SHALL be all zero and we SHALL be 0; grant SHALL first appear one cycle after req_valid is sampled.
REQ-018 In BUSY, req_ready SHALL be grant masked by !full, and all non-owner req_ready bits SHALL be 0.
REQ-019 SHALL define a transfer as BUSY && req_valid[owner] && !full.
REQ-020 we SHALL equal the transfer condition and wd SHALL equal req_data of the owner, both combinational.
REQ-021 Each transfer SHALL increment cnt.
REQ-022 The grant SHALL be released when a transfer makes cnt reach BURST.
REQ-023 The grant SHALL also be released in any BUSY cycle where req_valid[owner] is low; that release SHALL apply whether or not full is high.
REQ-024 While BUSY with full high and req_valid[owner] high, SHALL hold owner, grant and cnt unchanged with we=0.
REQ-025 On release, SHALL set ptr to (owner+1) mod R, clear grant and cnt, and enter IDLE on the next edge; re-arbitration then follows REQ-015.
REQ-026 Minimum gap between the last write of one grant and the first write of the next SHALL be 2 cycles.
REQ-027 we SHALL never be asserted when full is high.
REQ-028 grant SHALL never have more than one bit set.
REQ-029 Requester data SHALL never be dropped or duplicated: exactly one FIFO write per valid&&ready cycle.
REQ-030 Changes of non-owner req_valid during BUSY SHALL have no effect until the next IDLE cycle.

Reset
REQ-031 While reset is high, asynchronously and independent of clk: state=IDLE, ptr=0, cnt=0, owner=0, grant=0, busy=0.
REQ-032 While reset is high, req_ready=0 and we=0; wd is don't-care.
REQ-033 Reset asserted mid-grant SHALL abort the grant immediately; no write SHALL occur in that cycle.
REQ-034 After reset deassertion, first arbitration SHALL start from requester 0.

Verification
REQ-035 Single requester: req_valid=0001, data 1..6, full=0 -> grant=0001 one cycle later; writes 1,2,3,4; release; 2-cycle gap; writes 5,6.
REQ-036 Round-robin: req_valid=1111 held continuously -> grant order 0001,0010,0100,1000,0001; 4 writes per grant.
REQ-037 Backpressure: full=1 for 3 cycles mid-burst after 2 writes -> we=0 and cnt held at 2 during stall; 2 remaining writes follow.
REQ-038 Early drop: owner 2 drops valid after 1 write -> release; next grant goes to the lowest valid requester at or after index 3, wrapping.
REQ-039 Owner drops valid while full=1 -> release with no write; ptr advances.
REQ-040 Reset pulse asserted asynchronously mid-burst -> grant, we and busy go 0 before the next edge; next grant starts search at requester 0.
